// File: rtl/seq_gen_pkg.sv
// Shared mode encodings and default constants for the sequence generator.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_GRAY = 2'b10,
        MODE_LFSR = 2'b11
    } mode_e;

    localparam int unsigned     DEF_WIDTH   = 4;
    localparam longint unsigned DEF_MODULUS = 16;
    localparam logic [3:0]      DEF_TAPS    = 4'b1100;
    localparam logic [3:0]      DEF_SEED    = 4'b0001;

endpackage

// File: rtl/seq_gen_lfsr_next.sv
// Fibonacci LFSR next-state with all-zero lockup recovery to SEED.
module seq_gen_lfsr_next #(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'b1100),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(4'b0001)
) (
    input  logic [WIDTH-1:0] cnt_i,
    output logic [WIDTH-1:0] nxt_c_o
);

    // Shift left, feeding back the parity of the tapped bits; zero restarts at SEED.
    always_comb begin
        nxt_c_o = {cnt_i[WIDTH-2:0], ^(cnt_i & TAPS)};
        if (cnt_i == '0) begin
            nxt_c_o = SEED;
        end
    end

endmodule

// File: rtl/seq_gen.sv
// Multi-mode sequence generator: modulo up/down counter, Gray counter, LFSR.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter longint unsigned  MODULUS   = DEF_MODULUS,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(DEF_SEED),
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       MODE,
    output logic [WIDTH-1:0] Q,
    output logic             TC
);

    // Highest in-range count, and the modulus widened so 2^WIDTH still fits.
    localparam logic [WIDTH-1:0] MOD_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] lfsr_nxt;

    seq_gen_lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .cnt_i   (cnt_q),
        .nxt_c_o (lfsr_nxt)
    );

    // State register with asynchronous reset to RESET_VAL.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= RESET_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Next state: load beats advance beats hold; out-of-range values recover on advance.
    always_comb begin
        cnt_d = cnt_q;
        if (LD) begin
            cnt_d = D;
        end else if (EN) begin
            case (MODE)
                MODE_UP: begin
                    if (cnt_q >= MOD_MAX) cnt_d = '0;
                    else                  cnt_d = cnt_q + WIDTH'(1);
                end
                MODE_DOWN: begin
                    if (cnt_q == '0 || {1'b0, cnt_q} >= MOD_EXT) cnt_d = MOD_MAX;
                    else                                         cnt_d = cnt_q - WIDTH'(1);
                end
                MODE_GRAY: cnt_d = cnt_q + WIDTH'(1);
                MODE_LFSR: cnt_d = lfsr_nxt;
                default:   cnt_d = cnt_q;
            endcase
        end
    end

    // Output decode: Gray mapping and per-mode terminal count, independent of EN.
    always_comb begin
        Q  = cnt_q;
        TC = 1'b0;
        case (MODE)
            MODE_UP:   TC = (cnt_q == MOD_MAX);
            MODE_DOWN: TC = (cnt_q == '0);
            MODE_GRAY: begin
                Q  = cnt_q ^ (cnt_q >> 1);
                TC = (cnt_q == '1);
            end
            MODE_LFSR: TC = (cnt_q == SEED);
            default:   TC = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_seq_gen.sv
// Directed self-checking bench for seq_gen (default and MODULUS=10 instances).
module tb_seq_gen;
    import seq_gen_pkg::*;

    logic       clk;
    logic       rst;
    logic       en,   ld;
    logic [3:0] d;
    logic [1:0] mode;
    logic [3:0] q;
    logic       tc;
    logic       en10, ld10;
    logic [3:0] d10;
    logic [1:0] mode10;
    logic [3:0] q10;
    logic       tc10;

    int total = 0;
    int bad   = 0;

    seq_gen u_def (
        .CLK (clk), .RST (rst), .EN (en), .LD (ld), .D (d), .MODE (mode),
        .Q (q), .TC (tc)
    );

    seq_gen #(.WIDTH(4), .MODULUS(10)) u_m10 (
        .CLK (clk), .RST (rst), .EN (en10), .LD (ld10), .D (d10), .MODE (mode10),
        .Q (q10), .TC (tc10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] lfsr_tbl [15] = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110,
                                  4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111,
                                  4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
    logic [3:0] gray_tbl [16] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12,
                                  4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8, 4'd0};

    initial begin
        logic [3:0] prev;
        int         e10;
        rst = 1'b0; en = 1'b0; ld = 1'b0; d = '0; mode = MODE_UP;
        en10 = 1'b0; ld10 = 1'b0; d10 = '0; mode10 = MODE_DOWN;

        // Reset state
        #2;
        chk("rst_q", q, 4'h0);
        chk("rst_tc", tc, 1'b0);
        chk("rst_q10", q10, 4'h0);
        chk("rst_tc10_down", tc10, 1'b1);

        // Release between edges, then count UP (default) and DOWN (mod 10)
        #10;
        rst = 1'b1; en = 1'b1; en10 = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("up_q_%0d", k), q, 32'(k % 16));
            chk($sformatf("up_tc_%0d", k), tc, (k == 15) ? 1'b1 : 1'b0);
            e10 = (k <= 10) ? 10 - k : 20 - k;
            chk($sformatf("down_q_%0d", k), q10, 32'(e10));
            chk($sformatf("down_tc_%0d", k), tc10, (e10 == 0) ? 1'b1 : 1'b0);
        end

        // DOWN recovery from an out-of-range load (LD wins over EN)
        ld10 = 1'b1; d10 = 4'b1100;
        step();
        chk("down_ld_q", q10, 4'b1100);
        ld10 = 1'b0;
        step();
        chk("down_recover_q", q10, 4'b1001);

        // Mode change reinterprets cnt: UP recovers 14 -> 0, LFSR recovers 0 -> SEED
        ld10 = 1'b1; d10 = 4'd14; mode10 = MODE_UP;
        step();
        ld10 = 1'b0;
        step();
        chk("up_recover_q", q10, 4'd0);
        mode10 = MODE_LFSR;
        step();
        chk("lfsr_lockup_q10", q10, 4'd1);
        chk("lfsr_lockup_tc10", tc10, 1'b1);
        en10 = 1'b0;

        // LD and EN together: load, no advance; then hold for 3 edges
        ld = 1'b1; en = 1'b1; d = 4'b0111;
        step();
        chk("ld_en_q", q, 4'b0111);
        ld = 1'b0; en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("hold_q_%0d", k), q, 4'b0111);
        end

        // LFSR full period from SEED
        mode = MODE_LFSR; ld = 1'b1; d = 4'b0001;
        step();
        chk("lfsr_seed_q", q, 4'b0001);
        chk("lfsr_seed_tc", tc, 1'b1);
        ld = 1'b0; en = 1'b1;
        for (int k = 0; k < 15; k++) begin
            step();
            chk($sformatf("lfsr_q_%0d", k + 1), q, lfsr_tbl[k]);
            chk($sformatf("lfsr_tc_%0d", k + 1), tc, (k == 14) ? 1'b1 : 1'b0);
        end

        // LFSR lockup: load zero, next advance restarts at SEED
        ld = 1'b1; d = 4'b0000;
        step();
        chk("lfsr_zero_q", q, 4'b0000);
        chk("lfsr_zero_tc", tc, 1'b0);
        ld = 1'b0;
        step();
        chk("lfsr_unlock_q", q, 4'b0001);

        // Gray view of cnt=1, then asynchronous reset between edges
        mode = MODE_GRAY; en = 1'b0;
        #1;
        chk("gray_view_q", q, 4'b0001);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_q", q, 4'b0000);
        chk("async_rst_tc", tc, 1'b0);
        #2;
        rst = 1'b1; en = 1'b1;

        // GRAY full wrap: table values and single-bit transitions
        prev = q;
        for (int k = 0; k < 16; k++) begin
            step();
            chk($sformatf("gray_q_%0d", k + 1), q, gray_tbl[k]);
            chk($sformatf("gray_1bit_%0d", k + 1), 32'($countones(q ^ prev)), 32'd1);
            chk($sformatf("gray_tc_%0d", k + 1), tc, (k == 14) ? 1'b1 : 1'b0);
            prev = q;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter/output width in bits (2..32).
REQ-002 The block SHALL have parameter MODULUS, default 16, giving the wrap count for UP/DOWN modes (2..2^WIDTH).
REQ-003 The block SHALL have parameter TAPS, default 4'b1100 (WIDTH bits), giving the LFSR feedback tap mask.
REQ-004 The block SHALL have parameter SEED, default 1, giving the LFSR restart value (nonzero).
REQ-005 The block SHALL have parameter RESET_VAL, default 0, giving the state register value in reset.
REQ-006 The block SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-008 The block SHALL have port EN  input  1  advance enable.
REQ-009 The block SHALL have port LD  input  1  synchronous load strobe.
REQ-010 The block SHALL have port D  input  WIDTH  load value.
REQ-011 The block SHALL have port MODE  input  2  sequence select: 00 UP, 01 DOWN, 10 GRAY, 11 LFSR.
REQ-012 The block SHALL have port Q  output  WIDTH  sequence output.
REQ-013 The block SHALL have port TC  output  1  terminal-count flag.

Function
REQ-014 The block SHALL hold one WIDTH-bit state register cnt; Q SHALL be cnt in UP/DOWN/LFSR modes and cnt^(cnt>>1) in GRAY mode (combinational from cnt and MODE).
REQ-015 Per rising edge, priority SHALL be LD > EN > hold: LD=1 loads cnt<=D regardless of EN/MODE; LD=0,EN=0 holds cnt.
REQ-016 UP, EN=1: cnt<=cnt+1; if cnt>=MODULUS-1 then cnt<=0.
REQ-017 DOWN, EN=1: cnt<=cnt-1; if cnt==0 or cnt>=MODULUS then cnt<=MODULUS-1.
REQ-018 GRAY, EN=1: cnt<=cnt+1 modulo 2^WIDTH (MODULUS ignored); Q steps by exactly one bit per advance.
REQ-019 LFSR, EN=1: cnt<={cnt[WIDTH-2:0], ^(cnt & TAPS)}; if cnt==0 (lockup) then cnt<=SEED.
REQ-020 TC SHALL be combinational from cnt/MODE: UP cnt==MODULUS-1; DOWN cnt==0; GRAY cnt=={WIDTH{1}}; LFSR cnt==SEED; TC is independent of EN.
REQ-021 A MODE change SHALL take effect at the next edge with no flush: the current cnt is reinterpreted under the new mode, with out-of-range values recovered per REQ-016/017/019.
REQ-022 Latency: Q/TC reflect a load or advance one edge after LD/EN is sampled; no other pipeline stage.

Reset
REQ-023 RST=0 SHALL force cnt=RESET_VAL immediately, asynchronously to CLK; Q and TC follow per REQ-014/020 (defaults: Q=0000, TC=0 in UP).
REQ-024 Reset deassertion SHALL be clean: the first edge with RST=1 performs a normal LD/EN step; assertion mid-sequence SHALL abandon the sequence with no residual state.

Structure
REQ-025 A shared package SHALL hold the MODE encodings (MODE_UP, MODE_DOWN, MODE_GRAY, MODE_LFSR) and the default TAPS/SEED constants.
REQ-026 The LFSR next-state and lockup logic SHALL be one sub-module, seq_gen_lfsr_next (combinational, WIDTH/TAPS/SEED parameters); all other logic SHALL be inline.

Verification
REQ-027 Defaults, UP, EN=1, RST pulsed low then released -> Q=0101 after 5 rising edges; Q=1111, TC=1 after 15; Q=0000 after 16.
REQ-028 Defaults, LFSR, LD=1 D=0001 one edge, then EN=1 -> Q=0010,0100,1001,0011,0110,1101...; returns to 0001 with TC=1 after 15 advances; load 0000 -> next advance gives 0001.
REQ-029 WIDTH=4, MODULUS=10, DOWN, after reset -> Q=1001 next edge, then 1000...0000 with TC=1 at 0000; load 1100 in DOWN -> next advance gives 1001.
REQ-030 GRAY, EN=1 from reset -> Q=0000,0001,0011,0010,0110; every transition differs by exactly one bit across a full 16-step wrap.
REQ-031 LD=1 and EN=1 on the same edge -> Q=D, no advance; EN=0 for 3 edges -> Q unchanged.
REQ-032 RST driven low between clock edges mid-count -> Q=RESET_VAL before the next CLK edge; resumes from RESET_VAL after release.
